// File: rtl/miner_job_ctrl.sv
// Upstream job controller for the Miner core: serves header words, steps the nonce,
// launches attempts and judges each result until a win, budget exhaustion or a stop.
module miner_job_ctrl #(
    parameter int HDR_WORDS      = 256,
    parameter int AW             = 8,
    parameter int NONCE_BYTE_LEN = 24
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        WrEn_I,
    input  logic [AW-1:0]               WrAddr_I,
    input  logic [31:0]                 WrData_I,
    input  logic [10:0]                 ByteNum_I,
    input  logic [NONCE_BYTE_LEN*8-1:0] NonceSeed_I,
    input  logic [31:0]                 MaxIter_I,
    input  logic                        Start_I,
    input  logic                        Stop_I,
    output logic                        Update_O,
    output logic [31:0]                 Msg_O,
    output logic [10:0]                 ByteNum_O,
    input  logic                        Next_I,
    output logic [NONCE_BYTE_LEN*8-1:0] Nonce_O,
    input  logic                        Rdy_I,
    input  logic                        Vld_I,
    input  logic [255:0]                Hash_I,
    output logic                        Busy_O,
    output logic                        Found_O,
    output logic                        Done_O,
    output logic [NONCE_BYTE_LEN*8-1:0] FoundNonce_O,
    output logic [255:0]                FoundHash_O,
    output logic [31:0]                 IterCnt_O
);

    localparam int NW = NONCE_BYTE_LEN * 8;
    localparam int HW = NW - 64;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, EVAL, FOUND, DONE} state_t;

    state_t         state, state_nx;
    logic [31:0]    mem [HDR_WORDS];
    logic [AW:0]    rd_ptr;
    logic [HW-1:0]  seed_hi;
    logic [63:0]    cnt;
    logic [31:0]    max_iter;
    logic           rdy_q;
    logic           vld_q;
    logic [255:0]   hash_q;
    logic           rdy_rise;
    logic           launch_job;
    logic [32:0]    iter_nx;
    logic           last_iter;

    assign rdy_rise   = Rdy_I & ~rdy_q;
    assign launch_job = ~Busy_O & Start_I & ~Stop_I;
    assign iter_nx    = {1'b0, IterCnt_O} + 33'd1;
    assign last_iter  = (max_iter != '0) && (iter_nx == {1'b0, max_iter});
    assign Nonce_O    = {seed_hi, cnt};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FOUND, DONE: if (launch_job) state_nx = LAUNCH;
            LAUNCH:            state_nx = Stop_I ? IDLE : WAIT;
            WAIT: begin
                if (Stop_I)        state_nx = IDLE;
                else if (rdy_rise) state_nx = EVAL;
            end
            EVAL: begin
                if (Stop_I)         state_nx = IDLE;
                else if (vld_q)     state_nx = FOUND;
                else if (last_iter) state_nx = DONE;
                else                state_nx = LAUNCH;
            end
            default:           state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy_O = (state == LAUNCH) || (state == WAIT) || (state == EVAL);
        Msg_O  = '0;
        if (rd_ptr < (AW+1)'(HDR_WORDS)) Msg_O = mem[rd_ptr[AW-1:0]];
    end

    // NOTE: the header buffer has no reset; its contents are undefined until loaded.
    always_ff @(posedge Clk) begin
        if (WrEn_I && !Busy_O && ({1'b0, WrAddr_I} < (AW+1)'(HDR_WORDS)))
            mem[WrAddr_I] <= WrData_I;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Update_O     <= 1'b0;
            rd_ptr       <= '0;
            rdy_q        <= 1'b0;
            vld_q        <= 1'b0;
            hash_q       <= '0;
            ByteNum_O    <= '0;
            seed_hi      <= '0;
            cnt          <= '0;
            max_iter     <= '0;
            IterCnt_O    <= '0;
            Found_O      <= 1'b0;
            Done_O       <= 1'b0;
            FoundNonce_O <= '0;
            FoundHash_O  <= '0;
        end else begin
            Update_O <= (state_nx == LAUNCH);
            rdy_q    <= Rdy_I;

            if (state == LAUNCH) rd_ptr <= '0;
            else if (Next_I)     rd_ptr <= rd_ptr + (AW+1)'(1);

            if (state == WAIT && rdy_rise) begin
                vld_q  <= Vld_I;
                hash_q <= Hash_I;
            end

            if (launch_job) begin
                ByteNum_O <= ByteNum_I;
                seed_hi   <= NonceSeed_I[NW-1:64];
                cnt       <= NonceSeed_I[63:0];
                max_iter  <= MaxIter_I;
                IterCnt_O <= '0;
                Found_O   <= 1'b0;
                Done_O    <= 1'b0;
            end

            if (state == EVAL) begin
                // Saturate rather than wrap on an unlimited job.
                if (!iter_nx[32]) IterCnt_O <= iter_nx[31:0];
                case (state_nx)
                    FOUND: begin
                        Found_O      <= 1'b1;
                        FoundNonce_O <= Nonce_O;
                        FoundHash_O  <= hash_q;
                    end
                    DONE:    Done_O <= 1'b1;
                    LAUNCH:  cnt    <= cnt + 64'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/miner_job_ctrl.md
Name: miner_job_ctrl

Overview:
- Upstream job controller for the Miner core.
- Holds the headerBlob in a word buffer that the host loads. Drives the nonce and pulses Update to launch each hashing attempt, then serves header words on the Miner's Next request.
- Evaluates each attempt's Rdy/Vld result. It either records a winning nonce/hash, steps the nonce and relaunches, or stops when the iteration budget is exhausted.

Parameters:
- HDR_WORDS, 256, depth of the header buffer in 32-bit words (1024 bytes max).
- AW, 8, header buffer address width; must satisfy 2**AW >= HDR_WORDS.
- NONCE_BYTE_LEN, 24, nonce length in bytes; nonce width is NONCE_BYTE_LEN*8.

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- WrEn_I  in  1  header buffer write strobe
- WrAddr_I  in  AW  header buffer word address
- WrData_I  in  32  header word, already byte-ordered for the Miner
- ByteNum_I  in  11  total chunk bytes (nonce + header), latched on Start_I
- NonceSeed_I  in  NONCE_BYTE_LEN*8  starting nonce, latched on Start_I
- MaxIter_I  in  32  attempt budget; 0 = unlimited; latched on Start_I
- Start_I  in  1  start job (single-cycle pulse)
- Stop_I  in  1  abort job
- Update_O  out  1  launch pulse to Miner Update_I
- Msg_O  out  32  header word to Miner Msg_I
- ByteNum_O  out  11  to Miner ByteNum_I
- Next_I  in  1  word request from Miner Next_O
- Nonce_O  out  NONCE_BYTE_LEN*8  to Miner Nonce_I
- Rdy_I  in  1  Miner Rdy_O
- Vld_I  in  1  Miner Vld_O
- Hash_I  in  256  Miner Hash_O
- Busy_O  out  1  job in progress
- Found_O  out  1  winning nonce captured
- Done_O  out  1  budget exhausted without a win
- FoundNonce_O  out  NONCE_BYTE_LEN*8  winning nonce
- FoundHash_O  out  256  winning hash
- IterCnt_O  out  32  completed attempts in the current job

Behaviour:
- Reset: all outputs 0, state IDLE, rd_ptr 0, buffer contents undefined.
- Buffer writes:
  - Accepted only when Busy_O=0; ignored while busy.
  - Addresses >= HDR_WORDS are ignored.
- Nonce_O = {seed upper bits, 64-bit counter}. Counter increments by 1 and wraps 2^64-1 -> 0; the upper bits never change.
- Msg_O = buf[rd_ptr], combinational read. Returns 0 if rd_ptr >= HDR_WORDS.
  - The Miner samples Msg_O in the same cycle Next_I=1; rd_ptr increments on that clock edge.
- Rdy edge: rdy_q registers Rdy_I. Rdy rise = Rdy_I & ~rdy_q.
- States:
  - IDLE / FOUND / DONE: Start_I latches ByteNum_I, NonceSeed_I and MaxIter_I, clears IterCnt_O, Found_O and Done_O, sets Busy_O=1, then -> LAUNCH.
  - LAUNCH, exactly 1 cycle: Update_O=1 (registered) and rd_ptr <= 0, then -> WAIT. Nonce_O is stable from LAUNCH until EVAL completes.
  - WAIT: rd_ptr advances on Next_I. On Rdy rise, capture Vld_I and Hash_I, then -> EVAL. An Rdy_I still high from the prior attempt is not an edge.
  - EVAL, 1 cycle: IterCnt_O <= IterCnt_O+1, then the first matching case applies:
    - Captured Vld=1: FoundNonce_O <= Nonce_O, FoundHash_O <= captured hash, Found_O=1, Busy_O=0, -> FOUND.
    - MaxIter!=0 and IterCnt_O+1==MaxIter: Done_O=1, Busy_O=0, -> DONE.
    - Otherwise: counter+1 -> LAUNCH.
- Relaunch latency: Rdy rise in cycle N gives EVAL in N+1 and Update_O in N+2.
- Stop_I in LAUNCH/WAIT/EVAL:
  - Next state IDLE, Busy_O=0, Update_O=0; Found_O and Done_O unchanged.
  - Stop_I has priority over every EVAL outcome.
- Start_I while busy is ignored. Simultaneous Start_I and Stop_I in IDLE: Stop wins, no start.
- Next_I outside WAIT: rd_ptr still advances, and is harmless because LAUNCH re-zeroes it.
- IterCnt_O saturates at 2^32-1.
- Reset mid-job returns everything to reset values immediately (asynchronous).

Test Plan:
- Load 10 words 0x11111111..0xAAAAAAAA, ByteNum_I=64, MaxIter_I=1, Start -> one Update_O pulse. Msg_O steps through words 0..9 on each Next_I. Rdy rise with Vld=0 -> Done_O=1, IterCnt_O=1, Busy_O=0.
- NonceSeed low 64 = 5, MaxIter=3, Miner model never valid -> three Update pulses with nonce low bits 5, 6, 7. Done_O=1, IterCnt_O=3. Each Update_O occurs 2 cycles after the corresponding Rdy rise.
- Model returns Vld=1 on attempt 2, hash 0x00..01 -> Found_O=1, FoundNonce_O low=seed+1, FoundHash_O=0x00..01, no further Update_O.
- Seed low 64 = 0xFFFFFFFFFFFFFFFF, upper bits 0xABCD..., MaxIter=2 -> second nonce low=0, upper bits unchanged.
- Stop_I asserted in WAIT -> IDLE next cycle, Busy_O=0, Done_O=0. Start afterwards relaunches from the freshly latched seed with IterCnt_O=0.
- WrEn_I during busy to addr 0 with 0xDEADBEEF -> buffer unchanged on next job; Rdy_I held high across LAUNCH does not trigger EVAL.
